ext_ref_out_gen: RTL and testbench

EXT_REF_OUT_GEN -- requirements
Module: ext_ref_out_gen

---
 rtl/ext_ref_pkg.sv | 19 +
 rtl/ext_ref_out_gen_if.sv | 34 +++
 rtl/ext_ref_sync.sv | 25 ++
 rtl/ext_ref_out_gen.sv | 138 +++++++++++++
 tb/tb_ext_ref_out_gen.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_ref_pkg.sv
// ext_ref_pkg: shared types and defaults for the external reference output
// generator.
//   state_e      : phase state machine encoding (IDLE / HIGH / LOW)
//   DIV_W_DEF    : default width of the phase length inputs
//   HI_LEN_DEF   : default high-phase length (10 MHz from 50 MHz)
//   LO_LEN_DEF   : default low-phase length  (10 MHz from 50 MHz)
package ext_ref_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_e;

    localparam int unsigned DIV_W_DEF  = 8;
    localparam int unsigned HI_LEN_DEF = 2;
    localparam int unsigned LO_LEN_DEF = 3;

endpackage

// File: rtl/ext_ref_out_gen_if.sv
// ext_ref_out_gen_if: control/status bundle of the reference output generator.
//   OUT_EN      : level request to drive the reference output
//   HI_LEN      : high-phase length in clock cycles (DIV_W bits)
//   LO_LEN      : low-phase length in clock cycles (DIV_W bits)
//   SYNC_IN     : asynchronous phase-realign request (rising edge)
//   REF_OUT     : registered reference clock output
//   OUT_ACTIVE  : generator is not idle
//   PERIOD_STB  : one-cycle pulse with each REF_OUT rising edge
//   CFG_ERR     : OUT_EN is blocked by a zero phase length
// Modports: master drives requests/config, slave is the generator.
interface ext_ref_out_gen_if
    import ext_ref_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
);
    logic             OUT_EN;
    logic [DIV_W-1:0] HI_LEN;
    logic [DIV_W-1:0] LO_LEN;
    logic             SYNC_IN;
    logic             REF_OUT;
    logic             OUT_ACTIVE;
    logic             PERIOD_STB;
    logic             CFG_ERR;

    modport master (
        output OUT_EN, HI_LEN, LO_LEN, SYNC_IN,
        input  REF_OUT, OUT_ACTIVE, PERIOD_STB, CFG_ERR
    );

    modport slave (
        input  OUT_EN, HI_LEN, LO_LEN, SYNC_IN,
        output REF_OUT, OUT_ACTIVE, PERIOD_STB, CFG_ERR
    );
endinterface

// File: rtl/ext_ref_sync.sv
// ext_ref_sync: two-flop synchronizer followed by a rising-edge detector.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   async_i : asynchronous input
//   rise_o  : one-cycle pulse on a synchronized rising edge
// Only built when EXT_REF_OUT_SYNC_EN is defined.
module ext_ref_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);
    // [0],[1] = synchronizer stages, [2] = previous synchronized value
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/ext_ref_out_gen.sv
// ext_ref_out_gen: programmable reference clock generator (HI_LEN high cycles
// followed by LO_LEN low cycles, repeating while OUT_EN is held).
//   CLK_LOW : single clock for all logic
//   RST_N   : asynchronous active-low reset
//   bus     : ext_ref_out_gen_if.slave (OUT_EN, HI_LEN, LO_LEN, SYNC_IN in;
//             REF_OUT, OUT_ACTIVE, PERIOD_STB, CFG_ERR out)
// Macro EXT_REF_OUT_SYNC_EN: when defined, SYNC_IN rising edges (after a
// 2-flop synchronizer) restart the high phase; when undefined SYNC_IN is
// ignored and no synchronizer is built.
module ext_ref_out_gen
    import ext_ref_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             CLK_LOW,
    input  logic             RST_N,
    ext_ref_out_gen_if.slave bus
);
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] hi_q, hi_d;
    logic [DIV_W-1:0] lo_q, lo_d;
    logic             ref_q, ref_d;
    logic             stb_q, stb_d;
    logic             err_q, err_d;
    logic             cfg_ok;
    logic             start;
    logic             sync_evt;

`ifdef EXT_REF_OUT_SYNC_EN
    logic sync_rise;

    ext_ref_sync u_sync (
        .clk_i   (CLK_LOW),
        .rst_ni  (RST_N),
        .async_i (bus.SYNC_IN),
        .rise_o  (sync_rise)
    );

    assign sync_evt = sync_rise & bus.OUT_EN;
`else
    logic unused_sync_in;
    assign unused_sync_in = bus.SYNC_IN;
    assign sync_evt       = 1'b0;
`endif

    // The high length is consumed directly when the counter is loaded at
    // HIGH entry; its shadow copy is held only alongside the low length.
    logic unused_hi_shadow;
    assign unused_hi_shadow = ^hi_q;

    always_ff @(posedge CLK_LOW or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ref_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ref_q   <= ref_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ref_d   = ref_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;
        start   = 1'b0;
        cfg_ok  = (bus.HI_LEN != '0) && (bus.LO_LEN != '0);

        unique case (state_q)
            IDLE: begin
                ref_d = 1'b0;
                if (bus.OUT_EN) begin
                    if (cfg_ok) start = 1'b1;
                    else        err_d = 1'b1;
                end
            end
            HIGH: begin
                // A sync event wins over the phase-end transition
                if (sync_evt && cfg_ok) begin
                    start = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = LOW;
                    ref_d   = 1'b0;
                    cnt_d   = lo_q - DIV_W'(1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            LOW: begin
                if (sync_evt && cfg_ok) begin
                    start = 1'b1;
                end else if (cnt_q == '0) begin
                    if (bus.OUT_EN && cfg_ok) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        err_d   = bus.OUT_EN;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ref_d   = 1'b0;
            end
        endcase

        // Common HIGH entry: lengths are sampled only here
        if (start) begin
            state_d = HIGH;
            hi_d    = bus.HI_LEN;
            lo_d    = bus.LO_LEN;
            cnt_d   = bus.HI_LEN - DIV_W'(1);
            ref_d   = 1'b1;
            stb_d   = 1'b1;
        end
    end

    assign bus.REF_OUT    = ref_q;
    assign bus.OUT_ACTIVE = (state_q != IDLE);
    assign bus.PERIOD_STB = stb_q;
    assign bus.CFG_ERR    = err_q;
endmodule

// File: tb/tb_ext_ref_out_gen.sv
// tb_ext_ref_out_gen: self-checking bench for ext_ref_out_gen.
// Table of length configurations, hand-written multi-cycle sequences, and a
// randomized run checked against a waveform-queue reference model.
module tb_ext_ref_out_gen;
    import ext_ref_pkg::*;

    localparam int unsigned W  = DIV_W_DEF;
    localparam int unsigned NV = 7;

    typedef struct {
        int unsigned hi;
        int unsigned lo;
        bit          exp_run;
        int unsigned exp_high;
        int unsigned exp_period;
    } vec_t;

    logic clk;
    logic rst_n;

    ext_ref_out_gen_if #(.DIV_W(W)) bus ();

    ext_ref_out_gen #(.DIV_W(W)) dut (
        .CLK_LOW (clk),
        .RST_N   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Reference model: remaining REF_OUT samples of the current period
    bit   exp_q[$];
    logic m_ref, m_stb, m_act, m_err;

    function automatic void chk1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    function automatic void chkn(string name, int unsigned act, int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_ref = 1'b0; m_stb = 1'b0; m_act = 1'b0; m_err = 1'b0;
    endfunction

    // One clock edge: a new period starts only when the previous one is used up
    function automatic void model_step(bit en, int unsigned h, int unsigned l);
        if (exp_q.size() == 0) begin
            if (en && h != 0 && l != 0) begin
                for (int unsigned i = 0; i < h; i++) exp_q.push_back(1'b1);
                for (int unsigned i = 0; i < l; i++) exp_q.push_back(1'b0);
                m_ref = exp_q.pop_front();
                m_stb = 1'b1; m_act = 1'b1; m_err = 1'b0;
            end else begin
                m_ref = 1'b0; m_stb = 1'b0; m_act = 1'b0; m_err = en;
            end
        end else begin
            m_ref = exp_q.pop_front();
            m_stb = 1'b0; m_act = 1'b1; m_err = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.OUT_EN  = 1'b0;
        bus.HI_LEN  = W'(HI_LEN_DEF);
        bus.LO_LEN  = W'(LO_LEN_DEF);
        bus.SYNC_IN = 1'b0;
        tick();
        tick();
        chk1("rst_ref", bus.REF_OUT, 1'b0);
        chk1("rst_act", bus.OUT_ACTIVE, 1'b0);
        chk1("rst_stb", bus.PERIOD_STB, 1'b0);
        chk1("rst_err", bus.CFG_ERR, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Bit k of each vector is the stimulus before / expectation after tick k
    task automatic run_seq(string tag, int unsigned n, logic [31:0] v_en, logic [31:0] v_sync,
                           int unsigned hi_at, int unsigned hi_new,
                           logic [31:0] e_ref, logic [31:0] e_stb, logic [31:0] e_act);
        for (int unsigned k = 1; k <= n; k++) begin
            bus.OUT_EN  = v_en[k];
            bus.SYNC_IN = v_sync[k];
            if (k == hi_at) bus.HI_LEN = W'(hi_new);
            tick();
            chk1($sformatf("%s_ref_c%0d", tag, k), bus.REF_OUT, e_ref[k]);
            chk1($sformatf("%s_stb_c%0d", tag, k), bus.PERIOD_STB, e_stb[k]);
            chk1($sformatf("%s_act_c%0d", tag, k), bus.OUT_ACTIVE, e_act[k]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [NV];
        int unsigned hc, pc;
        bit          found;
        bit          en;
        int unsigned h, l;

        rst_n = 1'b0;
        vecs[0] = '{2,   3,   1'b1, 2,   5};
        vecs[1] = '{1,   1,   1'b1, 1,   2};
        vecs[2] = '{4,   3,   1'b1, 4,   7};
        vecs[3] = '{1,   255, 1'b1, 1,   256};
        vecs[4] = '{255, 255, 1'b1, 255, 510};
        vecs[5] = '{0,   3,   1'b0, 0,   0};
        vecs[6] = '{5,   0,   1'b0, 0,   0};

        // Table: first period shape for each length configuration
        for (int i = 0; i < int'(NV); i++) begin
            do_reset();
            bus.HI_LEN = W'(vecs[i].hi);
            bus.LO_LEN = W'(vecs[i].lo);
            bus.OUT_EN = 1'b1;
            tick();
            chk1($sformatf("vec%0d_stb0", i), bus.PERIOD_STB, vecs[i].exp_run);
            chk1($sformatf("vec%0d_ref0", i), bus.REF_OUT, vecs[i].exp_run);
            chk1($sformatf("vec%0d_act0", i), bus.OUT_ACTIVE, vecs[i].exp_run);
            chk1($sformatf("vec%0d_err0", i), bus.CFG_ERR, !vecs[i].exp_run);
            hc    = (bus.REF_OUT === 1'b1) ? 1 : 0;
            pc    = 1;
            found = 1'b0;
            for (int k = 0; k < 520 && !found; k++) begin
                tick();
                if (bus.PERIOD_STB === 1'b1) begin
                    found = 1'b1;
                    chk1($sformatf("vec%0d_ref_at_stb", i), bus.REF_OUT, 1'b1);
                end else begin
                    pc++;
                    if (bus.REF_OUT === 1'b1) hc++;
                end
            end
            chk1($sformatf("vec%0d_second_stb", i), found, vecs[i].exp_run);
            if (vecs[i].exp_run) begin
                chkn($sformatf("vec%0d_high_cycles", i), hc, vecs[i].exp_high);
                chkn($sformatf("vec%0d_period", i), pc, vecs[i].exp_period);
            end
        end

        // OUT_EN dropped on the first high cycle: full period, then idle
        do_reset();
        run_seq("endrop", 7, 32'h2, 32'h0, 0, 0, 32'h6, 32'h2, 32'h3E);

        // HI_LEN 2->4 during LOW: applies from the next period only
        do_reset();
        run_seq("hichg", 15, 32'hFFFE, 32'h0, 4, 4, 32'hE3C6, 32'h2042, 32'hFFFE);

        // Zero high length blocks output and flags CFG_ERR
        do_reset();
        bus.HI_LEN = '0;
        bus.LO_LEN = W'(3);
        bus.OUT_EN = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk1($sformatf("cfg_ref_c%0d", k), bus.REF_OUT, 1'b0);
            chk1($sformatf("cfg_err_c%0d", k), bus.CFG_ERR, 1'b1);
            chk1($sformatf("cfg_act_c%0d", k), bus.OUT_ACTIVE, 1'b0);
        end
        bus.HI_LEN = W'(2);
        tick();
        chk1("cfg_fix_ref", bus.REF_OUT, 1'b1);
        chk1("cfg_fix_stb", bus.PERIOD_STB, 1'b1);
        chk1("cfg_fix_err", bus.CFG_ERR, 1'b0);

        // Reset mid-HIGH forces REF_OUT low without a clock edge
        do_reset();
        bus.OUT_EN = 1'b1;
        tick();
        chk1("arst_pre_ref", bus.REF_OUT, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_ref", bus.REF_OUT, 1'b0);
        chk1("arst_act", bus.OUT_ACTIVE, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        run_seq("arst_post", 6, 32'h7E, 32'h0, 0, 0, 32'h46, 32'h42, 32'h7E);

`ifdef EXT_REF_OUT_SYNC_EN
        // Sync restarts: mid-LOW, coinciding with LOW end, coinciding with HIGH end
        do_reset();
        bus.HI_LEN = W'(2);
        bus.LO_LEN = W'(6);
        run_seq("sync", 27, {27'h7FFFFFF, 1'b0},
                {27'b00_111_0000000_111_00000_111_0000, 1'b0}, 0, 0,
                {27'b0_1111_000000_11_000000_11_0000_11, 1'b0},
                {27'b00101_0000000_1_0000000_1_00000_1, 1'b0},
                {27'h7FFFFFF, 1'b0});
`endif

        // Randomized run against the reference model
        do_reset();
        bus.OUT_EN = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) bus.OUT_EN = ~bus.OUT_EN;
            if ($urandom_range(0, 29) == 0) bus.HI_LEN = W'($urandom_range(0, 5));
            if ($urandom_range(0, 29) == 0) bus.LO_LEN = W'($urandom_range(0, 5));
`ifndef EXT_REF_OUT_SYNC_EN
            bus.SYNC_IN = 1'($urandom_range(0, 1));
`endif
            en = bus.OUT_EN;
            h  = int'(bus.HI_LEN);
            l  = int'(bus.LO_LEN);
            tick();
            model_step(en, h, l);
            chk1($sformatf("rnd_ref_c%0d", c), bus.REF_OUT, m_ref);
            chk1($sformatf("rnd_stb_c%0d", c), bus.PERIOD_STB, m_stb);
            chk1($sformatf("rnd_act_c%0d", c), bus.OUT_ACTIVE, m_act);
            chk1($sformatf("rnd_err_c%0d", c), bus.CFG_ERR, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
